rv_ifu: RTL and testbench
=========================

RV_IFU -- requirements
Module: rv_IFU

Interface
REQ-001 Parameter WIDTH, 32: datapath and PC width.
REQ-002 Parameter RESET_PC, 32'h8000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request present.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  fetch address, word aligned.
REQ-008 imem_rsp_valid  input  1  instruction word returned.
REQ-009 imem_rsp_ready  output  1  IFU accepts response.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid.
REQ-012 redirect_valid  input  1  branch/jump redirect from EXU, one-cycle pulse.
REQ-013 redirect_pc  input  32  redirect target; bits [1:0] ignored, forced to 00.
REQ-014 IF_ID_valid  output  1  IF_ID_message valid for decode.
REQ-015 IF_ID_ready  input  1  decode accepts message.
REQ-016 IF_ID_message  output  64  {pc[31:0], inst[31:0]}, pc in upper half.
REQ-017 fetch_fault  output  1  level; high while in FAULT.

Function
REQ-018 FSM states: REQ, WAIT, HOLD, FAULT; at most one outstanding request.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc; on req handshake -> WAIT.
REQ-020 WAIT: imem_rsp_ready=1; on rsp handshake without err: capture {pc,data} into output register, pc <= pc+4 (mod 2^32), -> HOLD.
REQ-021 WAIT with rsp_err: -> FAULT, no message produced, pc unchanged.
REQ-022 HOLD: IF_ID_valid=1, message stable until handshake; on IF_ID_valid&IF_ID_ready -> REQ the following cycle.
REQ-023 Latency: rsp handshake in cycle N -> IF_ID_valid=1 in cycle N+1; IF_ID handshake in cycle M -> imem_req_valid=1 in cycle M+1.
REQ-024 imem_req_addr shall not change while imem_req_valid=1 and not accepted, except on redirect.
REQ-025 Redirect in REQ: pc <= redirect_pc; if request handshakes in the same cycle, the request counts as issued, drop flag set, -> WAIT.
REQ-026 Redirect in WAIT (or request accepted with redirect): drop flag set; matching response consumed and discarded (err ignored), then -> REQ with new pc; redirect coincident with response has the same effect.
REQ-027 Redirect in HOLD: IF_ID_valid deasserted next cycle, pc <= redirect_pc, -> REQ; a same-cycle IF_ID handshake still completes.
REQ-028 Redirect in FAULT: pc <= redirect_pc, fetch_fault cleared, -> REQ; only exit from FAULT.
REQ-029 Redirect takes priority over all other transitions in the same cycle.
REQ-030 imem_rsp_ready=0 outside WAIT; imem_req_valid=0 outside REQ.

Reset
REQ-031 While rst=0: state=REQ, pc=RESET_PC, drop flag=0, IF_ID_valid=0, IF_ID_message=0, fetch_fault=0, imem_rsp_ready=0, imem_req_valid=0.
REQ-032 imem_req_valid first asserted in the first clk edge cycle after rst deasserts.
REQ-033 Reset mid-transaction abandons any outstanding request; no tracking of late responses.

Structure
REQ-034 Shared package holds: FSM state encoding, IF_ID_WIDTH (64), RESET_PC default.
REQ-035 One sub-module natural: rv_IFU_pc (PC register with +4 and redirect mux).

Verification
REQ-036 Reset release, memory always ready, 1-cycle response, IF_ID_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued; messages {0x80000000,inst0}... in order.
REQ-037 IF_ID_ready=0 for 5 cycles in HOLD -> message stable, no new imem_req_valid; ready=1 -> next request at pc+4 next cycle.
REQ-038 Redirect to 0x80000103 during WAIT -> response discarded, next request addr 0x80000100, no IF_ID_valid for dropped word.
REQ-039 rsp_err=1 on fetch at 0x80000010 -> fetch_fault=1, no requests; redirect to 0x80000020 -> fault clears, request at 0x80000020.
REQ-040 pc=0xFFFFFFFC fetch -> next request at 0x00000000.
REQ-041 rst=0 asserted while WAIT -> all outputs reset immediately (asynchronous), first request after release at 0x80000000.

Source files
------------

// File: rtl/rv_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// decode message width and the default reset fetch address.
package rv_ifu_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } ifu_state_e;

    localparam int          IF_ID_WIDTH      = 64;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage : rv_ifu_pkg

// File: rtl/rv_ifu_if.sv
// Instruction memory request/response channels plus the IF->ID message
// channel. The master modport is the fetch unit side.
interface rv_ifu_if #(
    parameter int WIDTH = 32
);
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [WIDTH-1:0]     imem_req_addr;
    logic                 imem_rsp_valid;
    logic                 imem_rsp_ready;
    logic [WIDTH-1:0]     imem_rsp_data;
    logic                 imem_rsp_err;
    logic                 IF_ID_valid;
    logic                 IF_ID_ready;
    logic [2*WIDTH-1:0]   IF_ID_message;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        output imem_rsp_ready,
        input  imem_rsp_data,
        input  imem_rsp_err,
        output IF_ID_valid,
        input  IF_ID_ready,
        output IF_ID_message
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        input  imem_rsp_ready,
        output imem_rsp_data,
        output imem_rsp_err,
        input  IF_ID_valid,
        output IF_ID_ready,
        input  IF_ID_message
    );

endinterface : rv_ifu_if

// File: rtl/rv_ifu_pc.sv
// Program counter register: redirect load (word aligned) has priority
// over the sequential +4 step; wraps modulo 2^WIDTH.
module rv_ifu_pc #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Next PC selection: redirect target with low bits cleared, else +4, else hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {target_i[WIDTH-1:2], 2'b00};
        end else if (inc_i) begin
            pc_d = pc_q + WIDTH'(4);
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : rv_ifu_pc

// File: rtl/rv_ifu.sv
// Instruction fetch unit: single outstanding fetch, one-entry output
// register toward decode, redirect with stale-response dropping, and a
// sticky fault state left only by a redirect.
module rv_ifu
    import rv_ifu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    rv_ifu_if.master         bus,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             fetch_fault
);

    ifu_state_e           state_q, state_d;
    logic                 drop_q, drop_d;
    logic [2*WIDTH-1:0]   msg_q, msg_d;
    logic                 pc_load;
    logic                 pc_inc;
    logic [WIDTH-1:0]     pc;
    logic                 req_hs;
    logic                 rsp_hs;

    rv_ifu_pc #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load_i   (pc_load),
        .target_i (redirect_pc),
        .inc_i    (pc_inc),
        .pc_o     (pc)
    );

    // Handshake outputs decode straight from state; reset masks them at once.
    assign bus.imem_req_valid = rst && (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.imem_rsp_ready = rst && (state_q == ST_WAIT);
    assign bus.IF_ID_valid    = (state_q == ST_HOLD);
    assign bus.IF_ID_message  = msg_q;
    assign fetch_fault        = (state_q == ST_FAULT);

    assign req_hs = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_hs = bus.imem_rsp_valid && bus.imem_rsp_ready;

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        msg_d   = msg_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    if (req_hs) begin
                        // The request already left; its response must be thrown away.
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (req_hs) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    if (rsp_hs) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (rsp_hs) begin
                    if (drop_q) begin
                        // Stale word from before a redirect: discard, error included.
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (bus.imem_rsp_err) begin
                        state_d = ST_FAULT;
                    end else begin
                        msg_d   = {pc, bus.imem_rsp_data};
                        pc_inc  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_REQ;
                end else if (bus.IF_ID_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_FAULT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State, drop flag and decode message registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_REQ;
            drop_q  <= 1'b0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            msg_q   <= msg_d;
        end
    end

endmodule : rv_ifu

// File: tb/tb_rv_ifu.sv
// Directed table-driven bench for rv_ifu: one table row per clock cycle
// holding the inputs for that cycle and the outputs expected in it.
module tb_rv_ifu;
    import rv_ifu_pkg::*;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int checks;
    int errors;

    rv_ifu_if #(.WIDTH(32)) bus ();

    rv_ifu #(
        .WIDTH    (32),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] data;
        logic        err;
        logic        redir;
        logic [31:0] rpc;
        logic        if_rdy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_rr;
        logic        e_iv;
        logic [63:0] e_msg;
        logic        e_f;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic rq_rdy, input logic rsp_v,
                                input logic [31:0] data, input logic err,
                                input logic redir, input logic [31:0] rpc,
                                input logic if_rdy, input logic e_rv,
                                input logic [31:0] e_addr, input logic e_rr,
                                input logic e_iv, input logic [63:0] e_msg,
                                input logic e_f);
        vec_t v;
        v.rq_rdy = rq_rdy; v.rsp_v = rsp_v; v.data = data; v.err = err;
        v.redir = redir; v.rpc = rpc; v.if_rdy = if_rdy;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_rr = e_rr; v.e_iv = e_iv;
        v.e_msg = e_msg; v.e_f = e_f;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rv, input logic [31:0] addr,
                              input logic rr, input logic iv, input logic [63:0] msg,
                              input logic f);
        check({tag, " req_valid"}, 64'(bus.imem_req_valid), 64'(rv));
        check({tag, " req_addr"},  64'(bus.imem_req_addr),  64'(addr));
        check({tag, " rsp_ready"}, 64'(bus.imem_rsp_ready), 64'(rr));
        check({tag, " IF_ID_valid"}, 64'(bus.IF_ID_valid),  64'(iv));
        check({tag, " IF_ID_message"}, bus.IF_ID_message,   msg);
        check({tag, " fetch_fault"}, 64'(fetch_fault),      64'(f));
    endtask

    task automatic drive(input logic rq_rdy, input logic rsp_v, input logic [31:0] data,
                         input logic err, input logic redir, input logic [31:0] rpc,
                         input logic if_rdy);
        bus.imem_req_ready = rq_rdy;
        bus.imem_rsp_valid = rsp_v;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        redirect_valid     = redir;
        redirect_pc        = rpc;
        bus.IF_ID_ready    = if_rdy;
    endtask

    localparam logic [63:0] M0 = {32'h8000_0000, 32'h1111_1111};
    localparam logic [63:0] M1 = {32'h8000_0004, 32'h2222_2222};
    localparam logic [63:0] M2 = {32'h8000_0008, 32'h3333_3333};
    localparam logic [63:0] M3 = {32'h8000_0100, 32'h4444_4444};
    localparam logic [63:0] M4 = {32'hFFFF_FFFC, 32'h6666_6666};
    localparam logic [63:0] Z  = 64'h0;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);

        // rq rsp data err redir rpc ifr | rv addr rr iv msg f
        vecs[0]  = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h8000_0000,0,0,Z,0);
        vecs[1]  = mk(0,1,32'h1111_1111,0,0,32'h0,0,  0,32'h8000_0000,1,0,Z,0);
        vecs[2]  = mk(0,0,32'h0,0,0,32'h0,1,          0,32'h8000_0004,0,1,M0,0);
        vecs[3]  = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h8000_0004,0,0,M0,0);
        vecs[4]  = mk(0,1,32'h2222_2222,0,0,32'h0,0,  0,32'h8000_0004,1,0,M0,0);
        vecs[5]  = mk(0,0,32'h0,0,0,32'h0,1,          0,32'h8000_0008,0,1,M1,0);
        vecs[6]  = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h8000_0008,0,0,M1,0);
        vecs[7]  = mk(0,1,32'h3333_3333,0,0,32'h0,0,  0,32'h8000_0008,1,0,M1,0);
        // decode stalls for five cycles; memory inputs are busy but must be ignored
        vecs[8]  = mk(1,1,32'hAAAA_AAAA,0,0,32'h0,0,  0,32'h8000_000C,0,1,M2,0);
        vecs[9]  = mk(1,1,32'hAAAA_AAAA,0,0,32'h0,0,  0,32'h8000_000C,0,1,M2,0);
        vecs[10] = mk(1,1,32'hAAAA_AAAA,0,0,32'h0,0,  0,32'h8000_000C,0,1,M2,0);
        vecs[11] = mk(1,1,32'hAAAA_AAAA,0,0,32'h0,0,  0,32'h8000_000C,0,1,M2,0);
        vecs[12] = mk(1,1,32'hAAAA_AAAA,0,0,32'h0,0,  0,32'h8000_000C,0,1,M2,0);
        vecs[13] = mk(0,0,32'h0,0,0,32'h0,1,          0,32'h8000_000C,0,1,M2,0);
        vecs[14] = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h8000_000C,0,0,M2,0);
        // redirect while waiting; the in-flight word (with err) is dropped
        vecs[15] = mk(0,0,32'h0,0,1,32'h8000_0103,0,  0,32'h8000_000C,1,0,M2,0);
        vecs[16] = mk(0,1,32'hDEAD_BEEF,1,0,32'h0,0,  0,32'h8000_0100,1,0,M2,0);
        vecs[17] = mk(0,0,32'h0,0,0,32'h0,0,          1,32'h8000_0100,0,0,M2,0);
        vecs[18] = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h8000_0100,0,0,M2,0);
        vecs[19] = mk(0,1,32'h4444_4444,0,0,32'h0,0,  0,32'h8000_0100,1,0,M2,0);
        // redirect in HOLD together with a decode handshake
        vecs[20] = mk(0,0,32'h0,0,1,32'h8000_0010,1,  0,32'h8000_0104,0,1,M3,0);
        vecs[21] = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h8000_0010,0,0,M3,0);
        vecs[22] = mk(0,1,32'h0,1,0,32'h0,0,          0,32'h8000_0010,1,0,M3,0);
        // fault: no requests until a redirect
        vecs[23] = mk(1,1,32'h0,0,0,32'h0,1,          0,32'h8000_0010,0,0,M3,1);
        vecs[24] = mk(0,0,32'h0,0,1,32'h8000_0020,0,  0,32'h8000_0010,0,0,M3,1);
        // redirect coincident with request acceptance
        vecs[25] = mk(1,0,32'h0,0,1,32'h8000_0200,0,  1,32'h8000_0020,0,0,M3,0);
        vecs[26] = mk(0,1,32'h5555_5555,0,0,32'h0,0,  0,32'h8000_0200,1,0,M3,0);
        vecs[27] = mk(0,0,32'h0,0,1,32'hFFFF_FFFC,0,  1,32'h8000_0200,0,0,M3,0);
        // PC wrap-around
        vecs[28] = mk(1,0,32'h0,0,0,32'h0,0,          1,32'hFFFF_FFFC,0,0,M3,0);
        vecs[29] = mk(0,1,32'h6666_6666,0,0,32'h0,0,  0,32'hFFFF_FFFC,1,0,M3,0);
        vecs[30] = mk(0,0,32'h0,0,0,32'h0,1,          0,32'h0000_0000,0,1,M4,0);
        vecs[31] = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h0000_0000,0,0,M4,0);
        // redirect coincident with a response
        vecs[32] = mk(0,1,32'h7777_7777,0,1,32'h8000_0300,0, 0,32'h0000_0000,1,0,M4,0);
        vecs[33] = mk(1,0,32'h0,0,0,32'h0,0,          1,32'h8000_0300,0,0,M4,0);

        // reset state
        repeat (2) @(negedge clk);
        #1 check_outs("reset", 0, 32'h8000_0000, 0, 0, Z, 0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rq_rdy, vecs[i].rsp_v, vecs[i].data, vecs[i].err,
                  vecs[i].redir, vecs[i].rpc, vecs[i].if_rdy);
            #1 check_outs($sformatf("row%0d", i), vecs[i].e_rv, vecs[i].e_addr,
                          vecs[i].e_rr, vecs[i].e_iv, vecs[i].e_msg, vecs[i].e_f);
            @(negedge clk);
        end

        // unit is now in WAIT: asynchronous reset mid-transaction
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0);
        #1 check_outs("pre_async", 0, 32'h8000_0300, 1, 0, M4, 0);
        #2 rst = 1'b0;
        #1 check_outs("async_rst", 0, 32'h8000_0000, 0, 0, Z, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        #1 check_outs("post_rst_req", 1, 32'h8000_0000, 0, 0, Z, 0);
        @(negedge clk);
        drive(0, 1, 32'h89AB_CDEF, 0, 0, 32'h0, 0);
        #1 check_outs("post_rst_wait", 0, 32'h8000_0000, 1, 0, Z, 0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1);
        #1 check_outs("post_rst_hold", 0, 32'h8000_0004, 0, 1,
                      {32'h8000_0000, 32'h89AB_CDEF}, 0);
        @(negedge clk);
        #1 check_outs("post_rst_req2", 1, 32'h8000_0004, 0, 0,
                      {32'h8000_0000, 32'h89AB_CDEF}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rv_ifu
